key_debounce16: RTL and testbench

Input-conditioning stage for the 16-key priority-encoder lab design. Synchronises 16 raw, bouncing key inputs to `clk`, debounces each one on a shared sample tick, and produces clean key levels plus one-cycle press pulses. `keys_db[15:8]` drives the encoder's `ui_in[7:0]` and `keys_db[7:0]` drives its `uio_in[7:0]`, so bit 15 is the highest-priority key downstream.

---
 rtl/key_debounce16.sv | 183 ++++++++++++++++++
 tb/tb_key_debounce16.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce16.sv
// -----------------------------------------------------------------------------
// key_debounce16
//
// Input conditioning for the 16-key priority-encoder lab design. Each raw key
// is brought into the clk domain through a two-flop synchroniser, sampled on a
// shared prescaler tick, and accepted as a new level only after STABLE_TICKS
// consecutive samples disagree with the current debounced level.
// keys_db[15:8] feeds the encoder's ui_in[7:0] and keys_db[7:0] feeds its
// uio_in[7:0], so bit 15 is the highest-priority key downstream.
//
// Optional feature macro: KEY_REPEAT_EN
//   When defined, holding the same set of keys produces repeated key_pressed
//   pulses. The first repeat comes REPEAT_DELAY ticks after the last change,
//   and later repeats follow every REPEAT_RATE ticks. When it is not defined,
//   the repeat counter does not exist and REPEAT_* are ignored.
//
// Parameters
//   TICK_DIV     clock cycles per sample tick (>= 2)
//   STABLE_TICKS consecutive differing samples needed to accept a change (2..15)
//   REPEAT_DELAY ticks held before the first auto-repeat (KEY_REPEAT_EN only)
//   REPEAT_RATE  ticks between later auto-repeats (KEY_REPEAT_EN only)
//
// Ports
//   clk          single clock
//   rst          asynchronous, active-high reset
//   keys_in      raw, asynchronous key levels (1 = pressed)
//   keys_db      debounced key levels (registered)
//   key_pressed  one-cycle pulse per key on an accepted press (and on repeat)
//   any_key      OR of keys_db (registered, follows keys_db in the same cycle)
// -----------------------------------------------------------------------------
module key_debounce16 #(
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_TICKS = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] keys_in,
    output logic [15:0] keys_db,
    output logic [15:0] key_pressed,
    output logic        any_key
);

    localparam int             TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [3:0]     CNT_LAST  = 4'(STABLE_TICKS - 1);

    if (TICK_DIV < 2 || STABLE_TICKS < 2 || STABLE_TICKS > 15) begin : g_param_check
        $error("key_debounce16: TICK_DIV must be >= 2 and STABLE_TICKS in 2..15");
    end

    logic [15:0]   r_sync1;
    logic [15:0]   r_sync2;
    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;
    logic [3:0]    r_cnt [16];
    logic [15:0]   w_db_next;
    logic [15:0]   w_repeat;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser: keys_in is fully asynchronous to clk.
    // ------------------------------------------------------------------------
    // NOTE: clocked state is always assigned with <= so every flop samples the
    // pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= keys_in;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Sample-tick prescaler: tick is the last cycle of each TICK_DIV period.
    // ------------------------------------------------------------------------
    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Next debounced level: a channel toggles on the tick in which its count
    // of consecutive disagreeing samples reaches STABLE_TICKS.
    // ------------------------------------------------------------------------
    // NOTE: the default assignment at the top of the block gives every bit a
    // value on every path, so no latch is inferred.
    always_comb begin
        w_db_next = keys_db;
        for (int i = 0; i < 16; i++) begin
            if (w_tick && (r_sync2[i] != keys_db[i]) && (r_cnt[i] == CNT_LAST)) begin
                w_db_next[i] = ~keys_db[i];
            end
        end
    end

    // Per-channel agreement counters. A matching sample (a bounce back to the
    // current level) restarts the count; an accepted change also clears it,
    // so the count never exceeds STABLE_TICKS-1.
    // NOTE: this small counter array is reset explicitly because a key held
    // through reset must start a full debounce interval from zero; a large
    // RAM-style memory would normally be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_tick) begin
            for (int i = 0; i < 16; i++) begin
                if ((r_sync2[i] == keys_db[i]) || (r_cnt[i] == CNT_LAST)) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                end
            end
        end
    end

`ifdef KEY_REPEAT_EN
    // ------------------------------------------------------------------------
    // Auto-repeat: one shared tick counter, restarted by any change to the
    // debounced set and held at zero while no key is down. After reaching
    // REPEAT_DELAY it cycles between REPEAT_DELAY and REPEAT_DELAY+REPEAT_RATE,
    // firing each time it arrives at either point.
    // ------------------------------------------------------------------------
    localparam int            RW        = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_WRAP  = RW'(REPEAT_DELAY + REPEAT_RATE);

    logic [RW-1:0] r_rep_cnt;
    logic [RW-1:0] w_rep_inc;
    logic          w_rep_hold;
    logic          w_rep_fire;

    assign w_rep_inc  = r_rep_cnt + 1'b1;
    assign w_rep_hold = (w_db_next == keys_db) && (keys_db != '0);
    assign w_rep_fire = w_tick && w_rep_hold &&
                        ((w_rep_inc == REP_FIRST) || (w_rep_inc == REP_WRAP));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt <= '0;
        end else if (!w_rep_hold) begin
            r_rep_cnt <= '0;
        end else if (w_tick) begin
            r_rep_cnt <= (w_rep_inc == REP_WRAP) ? REP_FIRST : w_rep_inc;
        end
    end

    assign w_repeat = w_rep_fire ? keys_db : '0;
`else
    // Repeat disabled: the REPEAT_* parameters have no effect on this build.
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;

    assign w_repeat = '0;
`endif

    // ------------------------------------------------------------------------
    // Registered outputs. The press pulse and any_key are derived from the
    // next-state level so they change on the same edge as keys_db.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keys_db     <= '0;
            key_pressed <= '0;
            any_key     <= 1'b0;
        end else begin
            keys_db     <= w_db_next;
            key_pressed <= (w_db_next & ~keys_db) | w_repeat;
            any_key     <= |w_db_next;
        end
    end

endmodule

// File: tb/tb_key_debounce16.sv
// -----------------------------------------------------------------------------
// tb_key_debounce16
//
// Self-checking bench for key_debounce16 with TICK_DIV=4, STABLE_TICKS=3,
// REPEAT_DELAY=5, REPEAT_RATE=2. A reference model kept in the bench is
// stepped once per clock. Its rule is that a key changes level on a sample
// tick when the last STABLE_TICKS tick samples since reset all disagree with
// the current level. Directed scenarios add latency and pulse-count checks.
// -----------------------------------------------------------------------------
module tb_key_debounce16;

    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;
    localparam int REPEAT_DELAY = 5;
    localparam int REPEAT_RATE  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] keys_in = '0;
    logic [15:0] keys_db;
    logic [15:0] key_pressed;
    logic        any_key;

    int n_checks = 0;
    int n_errors = 0;

    key_debounce16 #(
        .TICK_DIV    (TICK_DIV),
        .STABLE_TICKS(STABLE_TICKS),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .keys_in    (keys_in),
        .keys_db    (keys_db),
        .key_pressed(key_pressed),
        .any_key    (any_key)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    logic [15:0] m_d1 = '0;          // keys_in one edge ago
    logic [15:0] m_d2 = '0;          // keys_in two edges ago
    logic [15:0] m_samples [$];      // tick samples since reset (last few)
    logic [15:0] m_db = '0;
    logic [15:0] m_pressed = '0;
    logic        m_any = 1'b0;
    int          m_edge = 0;         // clock edges since reset released
    int          m_hold = 0;         // ticks since the debounced set changed

    task automatic model_reset();
        m_d1 = '0;
        m_d2 = '0;
        m_samples.delete();
        m_db = '0;
        m_pressed = '0;
        m_any = 1'b0;
        m_edge = 0;
        m_hold = 0;
    endtask

    task automatic model_step();
        logic [15:0] nxt;
        logic        tick;
        logic        differ;
        if (rst) begin
            model_reset();
            return;
        end
        tick = (m_edge % TICK_DIV) == (TICK_DIV - 1);
        nxt  = m_db;
        if (tick) begin
            m_samples.push_back(m_d2);
            if (m_samples.size() > STABLE_TICKS) void'(m_samples.pop_front());
            if (m_samples.size() == STABLE_TICKS) begin
                for (int i = 0; i < 16; i++) begin
                    differ = 1'b1;
                    foreach (m_samples[k]) begin
                        if (m_samples[k][i] == m_db[i]) differ = 1'b0;
                    end
                    if (differ) nxt[i] = ~m_db[i];
                end
            end
        end
        m_pressed = nxt & ~m_db;
`ifdef KEY_REPEAT_EN
        if (nxt != m_db || nxt == '0) begin
            m_hold = 0;
        end else if (tick) begin
            m_hold++;
            if (m_hold == REPEAT_DELAY ||
                (m_hold > REPEAT_DELAY && ((m_hold - REPEAT_DELAY) % REPEAT_RATE) == 0)) begin
                m_pressed = m_pressed | m_db;
            end
        end
`endif
        m_db   = nxt;
        m_any  = |nxt;
        m_d2   = m_d1;
        m_d1   = keys_in;
        m_edge++;
    endtask

    // One clock: the model steps on the edge, and the caller resumes at the
    // following falling edge, where outputs are stable and inputs may change.
    task automatic step_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Release all keys long enough for any held key to be released.
    task automatic settle_idle();
        keys_in = '0;
        repeat (20) step_cycle();
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({keys_db, key_pressed, any_key} !== 33'h0) begin
            n_errors++;
            $display("FAIL reset_async: got db=%h kp=%h any=%b want all zero", keys_db, key_pressed, any_key);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step_cycle();
            n_checks++;
            if ({keys_db, key_pressed, any_key} !== {m_db, m_pressed, m_any}) begin
                n_errors++;
                $display("FAIL reset_model t=%0t: got db=%h kp=%h any=%b want db=%h kp=%h any=%b",
                         $time, keys_db, key_pressed, any_key, m_db, m_pressed, m_any);
            end
        end
        n_checks++;
        if ({keys_db, key_pressed, any_key} !== 33'h0) begin
            n_errors++;
            $display("FAIL reset_idle: got db=%h kp=%h any=%b want all zero", keys_db, key_pressed, any_key);
        end
    endtask

    task automatic test_press();
        int          lat;
        int          pulses;
        logic [15:0] pval;
        lat    = -1;
        pulses = 0;
        pval   = '0;
        keys_in = 16'h0020;
        for (int n = 1; n <= 18; n++) begin
            step_cycle();
            n_checks++;
            if ({keys_db, key_pressed, any_key} !== {m_db, m_pressed, m_any}) begin
                n_errors++;
                $display("FAIL press_model t=%0t: got db=%h kp=%h any=%b want db=%h kp=%h any=%b",
                         $time, keys_db, key_pressed, any_key, m_db, m_pressed, m_any);
            end
            if (key_pressed !== 16'h0) begin
                pulses++;
                if (lat < 0) begin
                    lat  = n;
                    pval = key_pressed;
                end
            end
        end
        n_checks++;
        if (lat < (STABLE_TICKS - 1) * TICK_DIV + 2 || lat > STABLE_TICKS * TICK_DIV + 3) begin
            n_errors++;
            $display("FAIL press_latency: got %0d cycles want 10..15", lat);
        end
        n_checks++;
        if (pulses != 1 || pval !== 16'h0020) begin
            n_errors++;
            $display("FAIL press_pulse: got %0d pulses first=%h want 1 pulse of 0020", pulses, pval);
        end
        n_checks++;
        if (keys_db !== 16'h0020 || any_key !== 1'b1) begin
            n_errors++;
            $display("FAIL press_level: got db=%h any=%b want db=0020 any=1", keys_db, any_key);
        end
    endtask

    task automatic test_glitch();
        settle_idle();
        keys_in = 16'h0001;
        for (int n = 0; n < 40; n++) begin
            if (n == 4) keys_in = 16'h0000;
            step_cycle();
            n_checks++;
            if ({keys_db, key_pressed, any_key} !== {m_db, m_pressed, m_any}) begin
                n_errors++;
                $display("FAIL glitch_model t=%0t: got db=%h kp=%h any=%b want db=%h kp=%h any=%b",
                         $time, keys_db, key_pressed, any_key, m_db, m_pressed, m_any);
            end
            n_checks++;
            if ({keys_db, key_pressed, any_key} !== 33'h0) begin
                n_errors++;
                $display("FAIL glitch_reject t=%0t: got db=%h kp=%h any=%b want all zero",
                         $time, keys_db, key_pressed, any_key);
            end
        end
    endtask

    task automatic test_bounce();
        int pulses;
        int seen;
        int late;
        int n;
        pulses = 0;
        settle_idle();
        for (int c = 0; c < 40; c++) begin
            keys_in = ((c / 3) % 2 == 0) ? 16'h0200 : 16'h0000;
            step_cycle();
            n_checks++;
            if ({keys_db, key_pressed, any_key} !== {m_db, m_pressed, m_any}) begin
                n_errors++;
                $display("FAIL bounce_model t=%0t: got db=%h kp=%h any=%b want db=%h kp=%h any=%b",
                         $time, keys_db, key_pressed, any_key, m_db, m_pressed, m_any);
            end
            if (key_pressed[9]) pulses++;
        end
        keys_in = 16'h0200;
        n = 0;
        while (!keys_db[9] && n < 20) begin
            step_cycle();
            n++;
            n_checks++;
            if ({keys_db, key_pressed, any_key} !== {m_db, m_pressed, m_any}) begin
                n_errors++;
                $display("FAIL bounce_model t=%0t: got db=%h kp=%h any=%b want db=%h kp=%h any=%b",
                         $time, keys_db, key_pressed, any_key, m_db, m_pressed, m_any);
            end
            if (key_pressed[9]) pulses++;
        end
        n_checks++;
        if (pulses != 1 || keys_db !== 16'h0200) begin
            n_errors++;
            $display("FAIL bounce_press: got %0d pulses db=%h want 1 pulse db=0200", pulses, keys_db);
        end
        step_cycle();
        keys_in = 16'h0000;
        seen = 0;
        late = 0;
        for (int c = 0; c < 20; c++) begin
            step_cycle();
            n_checks++;
            if ({keys_db, key_pressed, any_key} !== {m_db, m_pressed, m_any}) begin
                n_errors++;
                $display("FAIL release_model t=%0t: got db=%h kp=%h any=%b want db=%h kp=%h any=%b",
                         $time, keys_db, key_pressed, any_key, m_db, m_pressed, m_any);
            end
            if (key_pressed !== 16'h0) late++;
            if (keys_db === 16'h0) seen = 1;
        end
        n_checks++;
        if (seen == 0 || late != 0 || any_key !== 1'b0) begin
            n_errors++;
            $display("FAIL release_nopulse: got released=%0d pulses=%0d any=%b want released=1 pulses=0 any=0",
                     seen, late, any_key);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        settle_idle();
        keys_in = 16'h8008;
        n = 0;
        while (keys_db === 16'h0 && n < 20) begin
            step_cycle();
            n++;
            n_checks++;
            if ({keys_db, key_pressed, any_key} !== {m_db, m_pressed, m_any}) begin
                n_errors++;
                $display("FAIL simul_model t=%0t: got db=%h kp=%h any=%b want db=%h kp=%h any=%b",
                         $time, keys_db, key_pressed, any_key, m_db, m_pressed, m_any);
            end
        end
        n_checks++;
        if (keys_db !== 16'h8008 || key_pressed !== 16'h8008 || any_key !== 1'b1) begin
            n_errors++;
            $display("FAIL simul_accept: got db=%h kp=%h any=%b want db=8008 kp=8008 any=1",
                     keys_db, key_pressed, any_key);
        end
        step_cycle();
        n_checks++;
        if (key_pressed !== 16'h0 || keys_db !== 16'h8008) begin
            n_errors++;
            $display("FAIL simul_single: got db=%h kp=%h want db=8008 kp=0000", keys_db, key_pressed);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int n;
        settle_idle();
        keys_in = 16'h0008;
        repeat (6) step_cycle();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({keys_db, key_pressed, any_key} !== 33'h0) begin
            n_errors++;
            $display("FAIL midreset_async: got db=%h kp=%h any=%b want all zero", keys_db, key_pressed, any_key);
        end
        repeat (2) begin
            step_cycle();
            n_checks++;
            if ({keys_db, key_pressed, any_key} !== 33'h0) begin
                n_errors++;
                $display("FAIL midreset_hold: got db=%h kp=%h any=%b want all zero", keys_db, key_pressed, any_key);
            end
        end
        rst = 1'b0;
        lat = -1;
        n = 0;
        while (lat < 0 && n < 20) begin
            step_cycle();
            n++;
            n_checks++;
            if ({keys_db, key_pressed, any_key} !== {m_db, m_pressed, m_any}) begin
                n_errors++;
                $display("FAIL midreset_model t=%0t: got db=%h kp=%h any=%b want db=%h kp=%h any=%b",
                         $time, keys_db, key_pressed, any_key, m_db, m_pressed, m_any);
            end
            if (key_pressed !== 16'h0) lat = n;
        end
        n_checks++;
        if (lat < 9 || lat > 15 || key_pressed !== 16'h0008) begin
            n_errors++;
            $display("FAIL midreset_repress: got latency=%0d kp=%h want 9..15 kp=0008", lat, key_pressed);
        end
    endtask

`ifdef KEY_REPEAT_EN
    task automatic test_repeat();
        int n;
        int offs [$];
        int seen;
        int late;
        settle_idle();
        keys_in = 16'h0080;
        n = 0;
        while (key_pressed === 16'h0 && n < 20) begin
            step_cycle();
            n++;
        end
        n_checks++;
        if (key_pressed !== 16'h0080) begin
            n_errors++;
            $display("FAIL repeat_first: got kp=%h want 0080", key_pressed);
        end
        for (int k = 1; k <= 37; k++) begin
            step_cycle();
            n_checks++;
            if ({keys_db, key_pressed, any_key} !== {m_db, m_pressed, m_any}) begin
                n_errors++;
                $display("FAIL repeat_model t=%0t: got db=%h kp=%h any=%b want db=%h kp=%h any=%b",
                         $time, keys_db, key_pressed, any_key, m_db, m_pressed, m_any);
            end
            if (key_pressed !== 16'h0) begin
                offs.push_back(k);
                n_checks++;
                if (key_pressed !== 16'h0080) begin
                    n_errors++;
                    $display("FAIL repeat_value: got kp=%h want 0080", key_pressed);
                end
            end
        end
        n_checks++;
        if (offs.size() != 3 || offs[0] != 20 || offs[1] != 28 || offs[2] != 36) begin
            n_errors++;
            $display("FAIL repeat_times: got offsets %p want 20 28 36", offs);
        end
        keys_in = 16'h0000;
        seen = 0;
        late = 0;
        for (int c = 0; c < 30; c++) begin
            step_cycle();
            if (seen != 0 && key_pressed !== 16'h0) late++;
            if (keys_db === 16'h0) seen = 1;
        end
        n_checks++;
        if (seen == 0 || late != 0) begin
            n_errors++;
            $display("FAIL repeat_stop: got released=%0d later_pulses=%0d want released=1 later_pulses=0",
                     seen, late);
        end
    endtask
`endif

    task automatic test_random();
        int len;
        keys_in = '0;
        for (int seg = 0; seg < 70; seg++) begin
            len = $urandom_range(1, 20);
            case ($urandom_range(0, 3))
                0:       keys_in = 16'($urandom);
                1:       keys_in = keys_in ^ (16'h1 << $urandom_range(0, 15));
                default: keys_in = keys_in;
            endcase
            if (seg == 35) begin
                #3;
                rst = 1'b1;
                model_reset();
                #1;
                n_checks++;
                if ({keys_db, key_pressed, any_key} !== 33'h0) begin
                    n_errors++;
                    $display("FAIL random_reset: got db=%h kp=%h any=%b want all zero",
                             keys_db, key_pressed, any_key);
                end
                @(negedge clk);
                rst = 1'b0;
            end
            for (int c = 0; c < len; c++) begin
                step_cycle();
                n_checks++;
                if ({keys_db, key_pressed, any_key} !== {m_db, m_pressed, m_any}) begin
                    n_errors++;
                    $display("FAIL random_model t=%0t: in=%h got db=%h kp=%h any=%b want db=%h kp=%h any=%b",
                             $time, keys_in, keys_db, key_pressed, any_key, m_db, m_pressed, m_any);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------------
    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
`ifdef KEY_REPEAT_EN
        test_repeat();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
